// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Core-wide constants shared by decode, writeback and the
//               register file. This covers the data width, the architectural
//               register count and the derived register address width.
// Revision    : 1.0 - initial multi-port register file release
// ============================================================================
package core_pkg;

    localparam int CORE_XLEN = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = $clog2(REG_DEPTH);

    typedef logic [REG_AW-1:0]    reg_addr_t;
    typedef logic [CORE_XLEN-1:0] reg_data_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_if
// Description : Bus bundle between the pipeline (decode/writeback, master)
//               and the multi-port register file (slave).
//   we/waddr/wdata   : NWP write ports, port k packed at [k*W +: W]
//   raddr            : NRP read addresses
//   rdata/rbusy      : combinational read data and pending flag per read port
//   sb_set/sb_addr   : mark a destination register pending
//   sb_flush         : clear every pending bit
// Revision    : 1.0 - initial multi-port register file release
// ============================================================================
interface regfile_mp_if
    import core_pkg::*;
#(
    parameter int XLEN = CORE_XLEN,
    parameter int AW   = REG_AW,
    parameter int NRP  = 2,
    parameter int NWP  = 1
);

    logic [NWP-1:0]      we;
    logic [NWP*AW-1:0]   waddr;
    logic [NWP*XLEN-1:0] wdata;
    logic [NRP*AW-1:0]   raddr;
    logic [NRP*XLEN-1:0] rdata;
    logic [NRP-1:0]      rbusy;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                sb_flush;

    modport master (
        output we, waddr, wdata, raddr, sb_set, sb_addr, sb_flush,
        input  rdata, rbusy
    );

    modport slave (
        input  we, waddr, wdata, raddr, sb_set, sb_addr, sb_flush,
        output rdata, rbusy
    );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : One pending bit per architectural register.
//   clk, rst  : clock and synchronous active-high reset
//   set       : mark set_addr pending at the edge
//   set_addr  : register to mark
//   flush     : clear all pending bits at the edge
//   clr       : per-register clear vector (effective writes this cycle)
//   pending   : current pending bits
// Priority at an edge: flush, then per-register clears, then the single set.
// A set therefore survives both a flush and a same-address clear.
// Revision    : 1.0 - initial multi-port register file release
// ============================================================================
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int DEPTH    = REG_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             set,
    input  wire logic [AW-1:0]    set_addr,
    input  wire logic             flush,
    input  wire logic [DEPTH-1:0] clr,
    output logic      [DEPTH-1:0] pending
);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_next;
    logic             w_set_ok;

    // Register 0 can never gain a producer when it is hard-wired to zero.
    assign w_set_ok = set && !((ZERO_REG != 0) && (set_addr == '0));

    always_comb begin
        w_next = flush ? '0 : (r_pending & ~clr);
        if (w_set_ok) begin
            w_next[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign pending = r_pending;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port integer register file with optional
//               write-to-read bypass, optional hard-wired zero register and a
//               per-register pending scoreboard for decode hazard stalls.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset. It clears storage and pending bits,
//          and forces rdata/rbusy to 0 while it is asserted.
//   bus  : regfile_mp_if slave (write ports, read ports, scoreboard control)
// Write-port priority: the highest port index wins on an address conflict.
// The bypass mux uses the same priority.
// Revision    : 1.0 - initial multi-port register file release
// ============================================================================
module regfile_mp
    import core_pkg::*;
#(
    parameter int XLEN     = CORE_XLEN,
    parameter int DEPTH    = REG_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRP      = 2,
    parameter int NWP      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_mp_if.slave bus
);

    logic [XLEN-1:0]  r_regs [DEPTH];
    logic [NWP-1:0]   w_wr_eff;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_pending;

    // A write is effective unless it targets the hard-wired zero register.
    for (genvar k = 0; k < NWP; k++) begin : g_weff
        assign w_wr_eff[k] = bus.we[k] &&
                             !((ZERO_REG != 0) && (bus.waddr[k*AW +: AW] == '0));
    end

    // Storage update. Later loop iterations override earlier ones, so the
    // highest-index write port wins on an address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWP; k++) begin
                if (w_wr_eff[k]) begin
                    r_regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Every effective write retires the producer of its destination.
    always_comb begin
        w_clr = '0;
        for (int k = 0; k < NWP; k++) begin
            if (w_wr_eff[k]) begin
                w_clr[bus.waddr[k*AW +: AW]] = 1'b1;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set      (bus.sb_set),
        .set_addr (bus.sb_addr),
        .flush    (bus.sb_flush),
        .clr      (w_clr),
        .pending  (w_pending)
    );

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_hit;
        logic [XLEN-1:0] w_byp;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_ra = bus.raddr[p*AW +: AW];

        // Find the winning same-cycle write to this read address.
        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int k = 0; k < NWP; k++) begin
                if (w_wr_eff[k] && (bus.waddr[k*AW +: AW] == w_ra)) begin
                    w_hit = 1'b1;
                    w_byp = bus.wdata[k*XLEN +: XLEN];
                end
            end
        end

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (rst) begin
                w_data = '0;
                w_busy = 1'b0;
            end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end else if ((BYPASS != 0) && w_hit) begin
                // The data is on the write bus now, so the reader need not stall.
                w_data = w_byp;
                w_busy = 1'b0;
            end else begin
                w_data = r_regs[w_ra];
                w_busy = w_pending[w_ra];
            end
        end

        assign bus.rdata[p*XLEN +: XLEN] = w_data;
        assign bus.rbusy[p]              = w_busy;
    end

endmodule : regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core. It is the successor of the single-write, dual-read register file.
- Adds configurable depth, width, read-port count and write-port count, plus same-cycle write-to-read bypass and a per-register pending scoreboard used by decode for hazard stalls.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- XLEN, 32, data width in bits
- DEPTH, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(DEPTH), address width (derived; do not override)
- NRP, 2, number of read ports (1..4)
- NWP, 1, number of write ports (1..2)
- BYPASS, 1, 1 = a read of an address written this cycle returns the write data
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous reset, active-high
- we  in  NWP  write enable per write port
- waddr  in  NWP*AW  write address, port k at [k*AW +: AW]
- wdata  in  NWP*XLEN  write data, port k at [k*XLEN +: XLEN]
- raddr  in  NRP*AW  read address per read port
- rdata  out  NRP*XLEN  read data per read port (combinational)
- rbusy  out  NRP  1 = register addressed by the read port has a pending producer
- sb_set  in  1  mark register sb_addr pending (instruction issued with a destination)
- sb_addr  in  AW  destination address to mark pending
- sb_flush  in  1  clear all pending bits (pipeline flush)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled at a clk edge with rst=1:
  - all DEPTH registers become 0 and all pending bits become 0;
  - while rst=1, rdata=0 and rbusy=0 on every port, regardless of other inputs;
  - writes, sb_set and sb_flush in a reset cycle are discarded.
- Write:
  - on a rising edge with we[k]=1, write wdata[k] into the register at waddr[k];
  - if ZERO_REG=1 and waddr[k]=0, the write is ignored;
  - both write ports hitting the same address in one cycle: port NWP-1 (highest index) wins.
- Read:
  - combinational, zero-cycle latency;
  - ZERO_REG=1 and raddr=0 gives rdata=0 and rbusy=0;
  - BYPASS=1: if any we[k]=1 with waddr[k]=raddr (and the address is not register 0 when ZERO_REG=1), rdata equals the winning wdata, using the same priority as the write;
  - BYPASS=0: rdata shows the pre-edge register contents.
- Scoreboard (DEPTH pending bits):
  - set: sb_set=1 sets pending[sb_addr] at the edge;
  - clear: any effective write to address a clears pending[a] at the edge;
  - set and clear of the same address in one cycle: set wins (a new producer supersedes);
  - sb_flush=1 clears all bits at the edge; sb_set in the same cycle is still applied after the flush, so the flush takes priority except for that one set;
  - ZERO_REG=1: pending[0] is never set.
- rbusy[p]:
  - equals pending[raddr[p]] before the edge;
  - when BYPASS=1 and a same-cycle write to raddr[p] is clearing the bit, rbusy[p]=0, because the data is available via bypass.
- Indices ≥ DEPTH are impossible (AW sized exactly), so no out-of-range handling is needed.

Decomposition:
- Shared package core_pkg holds XLEN, REG_DEPTH and the derived address width constant used by decode/writeback.
- One sub-module, regfile_scoreboard, holds the pending-bit array and its set/clear/flush priority.
- Storage and bypass muxing stay in regfile_mp.

Test Plan:
- Reset clears: preload r5=32'hDEAD_BEEF, assert rst for one edge → raddr0=5 reads 0, rbusy=0; a write during rst is not retained afterwards.
- Zero register: write 32'h1234 to r0, then read r0 → 0; sb_set with sb_addr=0 → rbusy for r0 stays 0.
- Bypass: same cycle we=1, waddr=7, wdata=32'hA5A5_0001, raddr1=7 → rdata1=32'hA5A5_0001 with BYPASS=1; with BYPASS=0 it shows the old r7 value, and the next cycle shows the new value.
- Dual-write conflict (NWP=2): both ports write r9 with 32'h11 / 32'h22 → r9=32'h22, and the bypassed read in that cycle also returns 32'h22.
- Scoreboard: sb_set r3 → next cycle rbusy=1 for r3. Then write r3 and sb_set r3 in the same cycle → r3 stays busy. A later write to r3 without a set → not busy.
- Flush: set r1, r2, r4 pending, then sb_flush with sb_set r6 → only r6 busy afterwards.
